iomem_initiator: RTL and testbench
==================================

# iomem_initiator

Bus initiator for the picosoc `iomem` interface, the counterpart of the peripheral responders (such as the GPIO register) that sit on that bus. It accepts word commands from a command port and drives `iomem_valid`/`addr`/`wdata`/`wstrb`. Commands may be single or burst: a burst is a block read or a fill write over consecutive words. Each word returns one response with read data or a timeout error. It lets hardware engines or debug logic reach `iomem` peripherals without the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles `iomem_valid` may stay high without `iomem_ready` before abort. Range 1..65535; 0 disables the timeout.
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_addr` in 32: start byte address. Bits [1:0] are ignored and forced to 0.
- `cmd_wdata` in 32: write data, repeated for every word of a fill.
- `cmd_wstrb` in 4: byte strobes. 0 means read.
- `cmd_len` in 8: word count minus 1, so a burst is 1..256 words.
- `iomem_valid` out 1: bus request.
- `iomem_ready` in 1: one-cycle completion pulse from the responder.
- `iomem_addr` out 32: bus address.
- `iomem_wdata` out 32: bus write data.
- `iomem_wstrb` out 4: bus write strobes.
- `iomem_rdata` in 32: read data, valid in the cycle `iomem_ready` is high.
- `rsp_valid` out 1: response offered.
- `rsp_ready` in 1: response consumed when both are high.
- `rsp_rdata` out 32: captured read data. 0 for writes and errors.
- `rsp_err` out 1: this word timed out.
- `rsp_last` out 1: final response of the command, either the last word or an abort.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM with three states: IDLE, BUS, RSP.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake, latch:
    - addr = {cmd_addr[31:2], 2'b00}
    - wdata, wstrb
    - remaining = cmd_len
  - Then go to BUS.
- **BUS**
  - `iomem_valid`=1. `addr`, `wdata` and `wstrb` are held constant for the whole state.
  - On `iomem_ready`=1:
    - capture `iomem_rdata`, or 0 if wstrb≠0;
    - set err=0 and clear the timeout counter;
    - go to RSP.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`-1 with `iomem_ready` still low:
    - set err=1 and rdata=0;
    - go to RSP.
  - If `iomem_ready` arrives in the same cycle as the timeout, `iomem_ready` wins and err=0.
- **RSP**
  - `rsp_valid`=1.
  - `rsp_last` = (remaining==0) | err.
  - Hold all `rsp_*` outputs stable until `rsp_ready`.
  - On handshake:
    - if `rsp_last`, go to IDLE;
    - otherwise addr += 4 (32-bit modulo: 0xFFFF_FFFC wraps to 0x0000_0000), remaining -= 1, go to BUS.
- **Error abort**: after an err response, the remaining words of the burst are discarded. There is no retry.
- **Ignored bus inputs**: `iomem_ready` outside BUS is ignored. `iomem_rdata` is sampled only in the BUS state, in the cycle `iomem_ready` is high.
- **Registered outputs**: all outputs are registered or decoded directly from the state register. `cmd_ready` depends only on the state, not on `cmd_valid`.
- **Reset (`resetn` low, any time, including mid-burst)**:
  - state = IDLE immediately (asynchronous);
  - `iomem_valid`=0, `rsp_valid`=0, `busy`=0;
  - `iomem_addr`, `iomem_wdata`, `iomem_wstrb`, `rsp_rdata` = 0;
  - `rsp_err`=0, `rsp_last`=0;
  - timeout counter = 0.
  - `cmd_ready` is 0 during reset and 1 from the first clock edge after release.

## Timing
- **Command to bus**: command handshake at edge 0 → `iomem_valid` high after edge 0 (cycle 1).
- **Drop of valid**: `iomem_valid` drops on the edge that samples `iomem_ready`=1. This is compatible with responders that guard their logic with `!iomem_ready`.
- **Bus to response**: `rsp_valid` is high in the cycle after `iomem_ready`.
- **Registered one-cycle responder** (`iomem_ready` high in cycle 2): `rsp_valid` in cycle 3. With `rsp_ready` tied high, the next word's `iomem_valid` is in cycle 4, i.e. 3 cycles per word.
- **End of command**: `cmd_ready` returns on the edge after the last response handshake.
- **Timeout**: `rsp_valid` with err asserts `TIMEOUT_CYCLES` cycles after `iomem_valid` rose.
- **Back-to-back commands**: minimum gap of 1 IDLE cycle between commands.

## Test plan
- **Single write**
  - Stimulus: addr 0x0300_0000, wdata 0x0000_00A5, wstrb 0x3, len 0, responder = GPIO model with one-cycle ready.
  - Required: exactly one bus transaction; model register = 0xA5; rsp_err=0, rsp_last=1; `rsp_valid` 3 cycles after the command.
- **Read burst**
  - Stimulus: addr 0x0300_0000, wstrb 0, len 3, memory model returning the address as data.
  - Required: 4 responses with rdata 0x0300_0000, 0x0300_0004, 0x0300_0008, 0x0300_000C; `rsp_last` only on the 4th.
- **Timeout**
  - Stimulus: `TIMEOUT_CYCLES`=16, no responder, len 5.
  - Required: `iomem_valid` high for exactly 16 cycles; one response with err=1, last=1, rdata 0; then IDLE.
  - Ready-on-timeout case: `iomem_ready` pulsed on the 16th cycle → err=0.
- **Back-pressure**
  - Stimulus: read len 1, `rsp_ready` low for 10 cycles.
  - Required: `rsp_*` outputs stable throughout; no second `iomem_valid` until after the handshake.
- **Address wrap and misalignment**
  - Stimulus: cmd_addr 0xFFFF_FFFE, len 1.
  - Required: bus addresses 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-burst**
  - Stimulus: assert `resetn` low while in BUS during word 2 of 4.
  - Required: `iomem_valid`, `rsp_valid` and `busy` fall without waiting for a clock edge; after release, `cmd_ready`=1 and a new command runs normally.

Source files
------------

// File: rtl/iomem_initiator.sv
// iomem_initiator: command-driven picosoc iomem bus initiator with bursts, timeout abort and per-word responses
module iomem_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [7:0]  cmd_len,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [7:0] rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d, last_q, last_d, init_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      last_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      last_q <= last_d;
      init_q <= 1'b1;
    end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    last_d = last_q;
    case (state_q)
      IDLE:
        if (cmd_valid && init_q) begin
          addr_d = cmd_addr & ~32'h3;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          rem_d = cmd_len;
          cnt_d = '0;
          state_d = BUS;
        end
      BUS:
        // a ready arriving on the timeout cycle still completes the word normally
        if (iomem_ready) begin
          rdata_d = (wstrb_q != 4'h0) ? 32'h0 : iomem_rdata;
          err_d = 1'b0;
          last_d = rem_q == 8'h0;
          cnt_d = '0;
          state_d = RSP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d = 1'b1;
          last_d = 1'b1;
          cnt_d = '0;
          state_d = RSP;
        end else cnt_d = cnt_q + 16'd1;
      RSP:
        if (rsp_ready) begin
          state_d = last_q ? IDLE : BUS;
          addr_d = last_q ? addr_q : addr_q + 32'd4;
          rem_d = last_q ? rem_q : rem_q - 8'd1;
        end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = (state_q == IDLE) && init_q;
  assign iomem_valid = state_q == BUS;
  assign rsp_valid = state_q == RSP;
  assign busy = state_q != IDLE;
  assign iomem_addr = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign rsp_last = last_q;
endmodule

// File: tb/tb_iomem_initiator.sv
// tb_iomem_initiator: directed scoreboard bench for iomem_initiator with a delay-programmable responder
module tb_iomem_initiator;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic [7:0] cmd_len = '0;
  logic iomem_valid, iomem_ready = 1'b0;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata = '0;
  logic [3:0] iomem_wstrb;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_last, busy;
  logic [31:0] rsp_rdata;
  int checks = 0, failures = 0;
  int dly = 1, vcnt = 0, txn_cnt = 0;
  logic [31:0] gpio_q = '0;
  typedef struct {logic [31:0] d; logic e; logic l;} rsp_t;
  rsp_t q[$];

  iomem_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_len(cmd_len),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // responder: memory returning the address as read data, GPIO-style register for writes; dly=0 never answers
  always @(posedge clk) begin
    if (iomem_valid && !iomem_ready) begin
      if (dly != 0 && vcnt + 1 == dly) begin
        iomem_ready <= 1'b1;
        iomem_rdata <= iomem_addr;
        vcnt <= 0;
        for (int b = 0; b < 4; b++) if (iomem_wstrb[b]) gpio_q[8*b+:8] <= iomem_wdata[8*b+:8];
      end else begin
        iomem_ready <= 1'b0;
        vcnt <= vcnt + 1;
      end
    end else begin
      iomem_ready <= 1'b0;
      vcnt <= 0;
    end
    if (iomem_valid && iomem_ready) txn_cnt <= txn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic l);
    rsp_t r;
    r.d = d; r.e = e; r.l = l;
    q.push_back(r);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_len = len;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    rsp_t r;
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_sb"}, 32'(q.size() != 0), 32'd1);
    if (rsp_valid && q.size() != 0) begin
      r = q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, r.d);
      chk({tag, "_err"}, 32'(rsp_err), 32'(r.e));
      chk({tag, "_last"}, 32'(rsp_last), 32'(r.l));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    logic [31:0] sd;
    logic se, sl, ok;
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", iomem_addr, 32'h0);
    chk("rst_wstrb", 32'(iomem_wstrb), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err_last", {30'h0, rsp_err, rsp_last}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // single write with timing
    t0 = txn_cnt;
    push(32'h0, 1'b0, 1'b1);
    send_cmd(32'h0300_0000, 32'h0000_00A5, 4'h3, 8'd0);
    @(negedge clk);
    chk("wr_valid_c1", 32'(iomem_valid), 32'd1);
    chk("wr_addr", iomem_addr, 32'h0300_0000);
    chk("wr_wstrb", 32'(iomem_wstrb), 32'h3);
    chk("wr_wdata", iomem_wdata, 32'hA5);
    @(negedge clk);
    chk("wr_rsp_c2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("wr_rsp_c3", 32'(rsp_valid), 32'd1);
    get_rsp("wr");
    chk("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("wr_gpio", gpio_q, 32'hA5);
    chk("wr_txn_count", 32'(txn_cnt - t0), 32'd1);

    // read burst of 4
    for (int i = 0; i < 4; i++) push(32'h0300_0000 + 32'(4 * i), 1'b0, i == 3);
    send_cmd(32'h0300_0000, 32'h0, 4'h0, 8'd3);
    for (int i = 0; i < 4; i++) get_rsp("rd");
    chk("rd_idle", 32'(busy), 32'd0);

    // timeout with no responder
    dly = 0;
    push(32'h0, 1'b1, 1'b1);
    send_cmd(32'h0200_0000, 32'h0, 4'h0, 8'd5);
    @(negedge clk);
    n = 0;
    while (iomem_valid && n < 100) begin n++; @(negedge clk); end
    chk("to_valid_cycles", 32'(n), 32'd16);
    chk("to_rsp_now", 32'(rsp_valid), 32'd1);
    get_rsp("to");
    repeat (3) @(negedge clk);
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_no_more_rsp", 32'(rsp_valid), 32'd0);

    // ready on the timeout cycle wins
    dly = 15;
    push(32'h0000_0100, 1'b0, 1'b1);
    send_cmd(32'h0000_0100, 32'h0, 4'h0, 8'd0);
    get_rsp("to_ready");
    dly = 1;

    // back-pressure
    push(32'h0300_0010, 1'b0, 1'b0);
    push(32'h0300_0014, 1'b0, 1'b1);
    send_cmd(32'h0300_0010, 32'h0, 4'h0, 8'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    sd = rsp_rdata; se = rsp_err; sl = rsp_last; ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= rsp_valid && rsp_rdata === sd && rsp_err === se && rsp_last === sl && !iomem_valid;
    end
    chk("bp_stable", 32'(ok), 32'd1);
    get_rsp("bp0");
    chk("bp_next_valid", 32'(iomem_valid), 32'd1);
    get_rsp("bp1");

    // address wrap and misalignment
    push(32'hFFFF_FFFC, 1'b0, 1'b0);
    push(32'h0000_0000, 1'b0, 1'b1);
    send_cmd(32'hFFFF_FFFE, 32'h0, 4'h0, 8'd1);
    chk("wrap_addr0", iomem_addr, 32'hFFFF_FFFC);
    get_rsp("wrap0");
    chk("wrap_addr1", iomem_addr, 32'h0000_0000);
    get_rsp("wrap1");

    // reset during word 2 of a 4-word burst
    for (int i = 0; i < 4; i++) push(32'h0300_0000 + 32'(4 * i), 1'b0, i == 3);
    send_cmd(32'h0300_0000, 32'h0, 4'h0, 8'd3);
    get_rsp("mid0");
    @(negedge clk);
    chk("mid_in_bus", 32'(iomem_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(iomem_valid), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
    push(32'h0, 1'b0, 1'b1);
    send_cmd(32'h0300_0000, 32'h1234_5678, 4'hF, 8'd0);
    get_rsp("mid_new");
    chk("mid_new_gpio", gpio_q, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
